alarm_trigger: RTL and testbench

- Consumer side of the alarm-set registers. Takes the stored alarm time (MERIDIEM/HOUR/MIN/SEC) and the running clock time, and detects a match.
- On a match it rings, drives a gated beep output, and handles dismiss and snooze from the synchronized button pulses.
- Sits beside the alarm-set mode block. Its outputs feed the buzzer pin and the display/LED logic.

---
 rtl/alarm_trigger_if.sv | 31 +++
 rtl/alarm_trigger.sv | 104 ++++++++++
 tb/tb_alarm_trigger.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/alarm_trigger_if.sv
// alarm_trigger_if: alarm compare inputs, button pulses and ring/buzz/snooze status outputs
interface alarm_trigger_if;
    logic       sec_tick;
    logic [3:0] num_sync;
    logic [3:0] mode;
    logic       alarm_en;
    logic       a_meridiem;
    logic [6:0] a_hour;
    logic [6:0] a_min;
    logic [6:0] a_sec;
    logic       c_meridiem;
    logic [6:0] c_hour;
    logic [6:0] c_min;
    logic [6:0] c_sec;
    logic       alarm_on;
    logic       buzz;
    logic       snoozing;
    logic [1:0] state;
    modport master (
        output sec_tick, num_sync, mode, alarm_en,
        output a_meridiem, a_hour, a_min, a_sec,
        output c_meridiem, c_hour, c_min, c_sec,
        input  alarm_on, buzz, snoozing, state
    );
    modport slave (
        input  sec_tick, num_sync, mode, alarm_en,
        input  a_meridiem, a_hour, a_min, a_sec,
        input  c_meridiem, c_hour, c_min, c_sec,
        output alarm_on, buzz, snoozing, state
    );
endinterface

// File: rtl/alarm_trigger.sv
// alarm_trigger: detects alarm/clock time match, rings with a gated beep, handles dismiss/snooze.
// Snooze is built only when ALARM_SNOOZE_EN is defined.
module alarm_trigger #(
    parameter int unsigned RING_SEC   = 60,
    parameter int unsigned SNOOZE_SEC = 300,
    parameter int unsigned BEEP_DIV   = 25000000
) (
    input  logic          i_clk,
    input  logic          i_rst,
    alarm_trigger_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, RINGING = 2'd2, SNOOZE = 2'd3} state_t;
    state_t      r_state, w_state_nxt;
    logic        r_match_d, r_buzz, w_buzz_nxt;
    logic [15:0] r_ring_cnt, w_ring_nxt, w_ring_inc;
    logic [25:0] r_beep_cnt, w_beep_nxt;
    logic        w_match, w_fire, w_beep_wrap;
    assign w_match = bus.a_meridiem == bus.c_meridiem && bus.a_hour == bus.c_hour &&
                     bus.a_min == bus.c_min && bus.a_sec == bus.c_sec && bus.mode != 4'b0000;
    assign w_fire      = w_match & ~r_match_d;
    assign w_ring_inc  = &r_ring_cnt ? r_ring_cnt : r_ring_cnt + 16'd1;
    assign w_beep_wrap = r_beep_cnt == 26'(BEEP_DIV - 1);
`ifdef ALARM_SNOOZE_EN
    logic [15:0] r_snz_cnt, w_snz_nxt, w_snz_inc;
    logic        w_unused;
    assign w_snz_inc = &r_snz_cnt ? r_snz_cnt : r_snz_cnt + 16'd1;
    assign w_unused  = ^bus.num_sync[3:2];
    always_ff @(posedge i_clk)
        if (i_rst) r_snz_cnt <= '0;
        else       r_snz_cnt <= w_snz_nxt;
`else
    logic w_unused;
    assign w_unused = ^bus.num_sync[3:1];
`endif
    always_comb begin
        w_state_nxt = r_state;
        w_ring_nxt  = r_ring_cnt;
        w_beep_nxt  = '0;
        w_buzz_nxt  = 1'b0;
`ifdef ALARM_SNOOZE_EN
        w_snz_nxt   = r_snz_cnt;
`endif
        case (r_state)
            IDLE: if (bus.alarm_en) w_state_nxt = ARMED;
            ARMED:
                if (!bus.alarm_en) w_state_nxt = IDLE;
                else if (w_fire) begin
                    w_state_nxt = RINGING;
                    w_ring_nxt  = '0;
                    w_buzz_nxt  = 1'b1;
                end
            RINGING:
                if (!bus.alarm_en) w_state_nxt = IDLE;
                else if (bus.num_sync[0]) w_state_nxt = ARMED;
`ifdef ALARM_SNOOZE_EN
                else if (bus.num_sync[1]) begin
                    w_state_nxt = SNOOZE;
                    w_snz_nxt   = '0;
                end
`endif
                else if (bus.sec_tick && w_ring_inc >= 16'(RING_SEC)) w_state_nxt = ARMED;
                else begin
                    w_ring_nxt = bus.sec_tick ? w_ring_inc : r_ring_cnt;
                    w_beep_nxt = w_beep_wrap ? '0 : r_beep_cnt + 26'd1;
                    w_buzz_nxt = w_beep_wrap ? ~r_buzz : r_buzz;
                end
`ifdef ALARM_SNOOZE_EN
            SNOOZE:
                if (!bus.alarm_en) w_state_nxt = IDLE;
                else if (bus.num_sync[0]) w_state_nxt = ARMED;
                else if (bus.sec_tick && w_snz_inc >= 16'(SNOOZE_SEC)) begin
                    w_state_nxt = RINGING;
                    w_ring_nxt  = '0;
                    w_buzz_nxt  = 1'b1;
                end
                else if (bus.sec_tick) w_snz_nxt = w_snz_inc;
`endif
            default: w_state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_match_d  <= 1'b0;
            r_ring_cnt <= '0;
            r_beep_cnt <= '0;
            r_buzz     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_match_d  <= w_match;
            r_ring_cnt <= w_ring_nxt;
            r_beep_cnt <= w_beep_nxt;
            r_buzz     <= w_buzz_nxt;
        end
    end
    assign bus.alarm_on = r_state == RINGING;
    assign bus.buzz     = r_buzz;
    assign bus.state    = r_state;
`ifdef ALARM_SNOOZE_EN
    assign bus.snoozing = r_state == SNOOZE;
`else
    assign bus.snoozing = 1'b0;
`endif
endmodule

// File: tb/tb_alarm_trigger.sv
// tb_alarm_trigger: directed checks of match/fire, beep, ring timeout, priorities, snooze and reset.
module tb_alarm_trigger;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;
    alarm_trigger_if bus();
    alarm_trigger #(.RING_SEC(3), .SNOOZE_SEC(2), .BEEP_DIV(4)) dut (
        .i_clk(clk), .i_rst(rst), .bus(bus.slave)
    );
    always #5 clk = ~clk;
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic sec_pulse();
        bus.sec_tick = 1'b1;
        step();
        bus.sec_tick = 1'b0;
    endtask
    task automatic retrigger();
        bus.mode = 4'b0000;
        step();
        bus.mode = 4'b0001;
        step();
    endtask
    task automatic test_reset();
        bus.sec_tick = 0; bus.num_sync = 0; bus.mode = 4'b0001; bus.alarm_en = 0;
        bus.a_meridiem = 0; bus.a_hour = 7; bus.a_min = 30; bus.a_sec = 0;
        bus.c_meridiem = 0; bus.c_hour = 7; bus.c_min = 29; bus.c_sec = 59;
        rst = 1;
        step();
        step();
        rst = 0;
        n_chk++; if (bus.state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", bus.state); end
        n_chk++; if ({bus.alarm_on, bus.buzz, bus.snoozing} !== 3'b000) begin n_fail++; $display("FAIL reset_outputs: got %b expected 000", {bus.alarm_on, bus.buzz, bus.snoozing}); end
    endtask
    task automatic test_fire();
        bus.alarm_en = 1;
        step();
        n_chk++; if (bus.state !== 2'd1) begin n_fail++; $display("FAIL fire_armed: got %0d expected 1", bus.state); end
        bus.c_min = 30; bus.c_sec = 0;
        #1;
        n_chk++; if (bus.state !== 2'd1) begin n_fail++; $display("FAIL fire_before_edge: got %0d expected 1", bus.state); end
        step();
        n_chk++; if (bus.state !== 2'd2) begin n_fail++; $display("FAIL fire_ringing: got %0d expected 2", bus.state); end
        n_chk++; if ({bus.alarm_on, bus.buzz} !== 2'b11) begin n_fail++; $display("FAIL fire_outputs: got %b expected 11", {bus.alarm_on, bus.buzz}); end
    endtask
    task automatic test_beep_ring();
        repeat (3) step();
        n_chk++; if (bus.buzz !== 1'b1) begin n_fail++; $display("FAIL beep_hold: got %b expected 1", bus.buzz); end
        step();
        n_chk++; if (bus.buzz !== 1'b0) begin n_fail++; $display("FAIL beep_toggle_low: got %b expected 0", bus.buzz); end
        repeat (3) step();
        n_chk++; if (bus.buzz !== 1'b0) begin n_fail++; $display("FAIL beep_hold_low: got %b expected 0", bus.buzz); end
        step();
        n_chk++; if (bus.buzz !== 1'b1) begin n_fail++; $display("FAIL beep_toggle_high: got %b expected 1", bus.buzz); end
        sec_pulse();
        sec_pulse();
        n_chk++; if (bus.state !== 2'd2) begin n_fail++; $display("FAIL ring_two_ticks: got %0d expected 2", bus.state); end
        sec_pulse();
        n_chk++; if (bus.state !== 2'd1) begin n_fail++; $display("FAIL ring_timeout: got %0d expected 1", bus.state); end
        n_chk++; if ({bus.alarm_on, bus.buzz} !== 2'b00) begin n_fail++; $display("FAIL ring_timeout_out: got %b expected 00", {bus.alarm_on, bus.buzz}); end
        step();
        n_chk++; if (bus.state !== 2'd1) begin n_fail++; $display("FAIL no_refire: got %0d expected 1", bus.state); end
    endtask
    task automatic test_mode_gate();
        bus.c_sec = 1;
        step();
        bus.mode = 4'b0000; bus.c_sec = 0;
        step();
        step();
        n_chk++; if (bus.state !== 2'd1) begin n_fail++; $display("FAIL mode_gate: got %0d expected 1", bus.state); end
        bus.mode = 4'b0001;
        step();
        n_chk++; if (bus.state !== 2'd2) begin n_fail++; $display("FAIL mode_release_fire: got %0d expected 2", bus.state); end
    endtask
    task automatic test_dismiss_priority();
        bus.num_sync = 4'b0011;
        step();
        bus.num_sync = 4'b0000;
        n_chk++; if (bus.state !== 2'd1) begin n_fail++; $display("FAIL dismiss_wins: got %0d expected 1", bus.state); end
        retrigger();
        n_chk++; if (bus.state !== 2'd2) begin n_fail++; $display("FAIL retrigger: got %0d expected 2", bus.state); end
        bus.num_sync = 4'b0001; bus.sec_tick = 1;
        step();
        bus.num_sync = 4'b0000; bus.sec_tick = 0;
        n_chk++; if (bus.state !== 2'd1) begin n_fail++; $display("FAIL dismiss_tick: got %0d expected 1", bus.state); end
        retrigger();
        bus.alarm_en = 0; bus.num_sync = 4'b0001;
        step();
        bus.num_sync = 4'b0000;
        n_chk++; if (bus.state !== 2'd0) begin n_fail++; $display("FAIL disable_wins: got %0d expected 0", bus.state); end
        n_chk++; if ({bus.alarm_on, bus.buzz} !== 2'b00) begin n_fail++; $display("FAIL disable_outputs: got %b expected 00", {bus.alarm_on, bus.buzz}); end
        bus.alarm_en = 1;
        step();
        step();
        n_chk++; if (bus.state !== 2'd1) begin n_fail++; $display("FAIL enable_in_match: got %0d expected 1", bus.state); end
    endtask
    task automatic test_snooze();
        retrigger();
        bus.num_sync = 4'b0010;
        step();
        bus.num_sync = 4'b0000;
`ifdef ALARM_SNOOZE_EN
        n_chk++; if (bus.state !== 2'd3) begin n_fail++; $display("FAIL snooze_enter: got %0d expected 3", bus.state); end
        n_chk++; if ({bus.snoozing, bus.alarm_on, bus.buzz} !== 3'b100) begin n_fail++; $display("FAIL snooze_outputs: got %b expected 100", {bus.snoozing, bus.alarm_on, bus.buzz}); end
        sec_pulse();
        n_chk++; if (bus.state !== 2'd3) begin n_fail++; $display("FAIL snooze_one_tick: got %0d expected 3", bus.state); end
        sec_pulse();
        n_chk++; if (bus.state !== 2'd2) begin n_fail++; $display("FAIL snooze_rering: got %0d expected 2", bus.state); end
        n_chk++; if ({bus.snoozing, bus.buzz} !== 2'b01) begin n_fail++; $display("FAIL snooze_rering_out: got %b expected 01", {bus.snoozing, bus.buzz}); end
`else
        n_chk++; if (bus.state !== 2'd2) begin n_fail++; $display("FAIL snooze_ignored: got %0d expected 2", bus.state); end
        n_chk++; if (bus.snoozing !== 1'b0) begin n_fail++; $display("FAIL snoozing_tied: got %b expected 0", bus.snoozing); end
`endif
    endtask
    task automatic test_reset_mid_ring();
        step();
        n_chk++; if (bus.state !== 2'd2) begin n_fail++; $display("FAIL pre_reset_ring: got %0d expected 2", bus.state); end
        rst = 1;
        step();
        rst = 0;
        n_chk++; if (bus.state !== 2'd0) begin n_fail++; $display("FAIL mid_reset_state: got %0d expected 0", bus.state); end
        n_chk++; if ({bus.alarm_on, bus.buzz, bus.snoozing} !== 3'b000) begin n_fail++; $display("FAIL mid_reset_out: got %b expected 000", {bus.alarm_on, bus.buzz, bus.snoozing}); end
        step();
        n_chk++; if (bus.state !== 2'd1) begin n_fail++; $display("FAIL post_reset_armed: got %0d expected 1", bus.state); end
        repeat (3) step();
        n_chk++; if (bus.state !== 2'd1) begin n_fail++; $display("FAIL post_reset_no_fire: got %0d expected 1", bus.state); end
        n_chk++; if (bus.buzz !== 1'b0) begin n_fail++; $display("FAIL post_reset_buzz: got %b expected 0", bus.buzz); end
    endtask
    initial begin
        test_reset();
        test_fire();
        test_beep_ring();
        test_mode_gate();
        test_dismiss_priority();
        test_snooze();
        test_reset_mid_ring();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
